cpu_loader: RTL
===============

CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 Parameter DATA_W, default 8, byte width of stream and CPU load data.
REQ-002 Parameter ADDR_W, default 5, CPU load-address width; depth is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  host byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready.
REQ-008 halt  input  1  stop a running CPU and return to loading.
REQ-009 clr_error  input  1  leave ERROR state.
REQ-010 cpu_input  output  DATA_W  byte driven to CPU load port.
REQ-011 load_address  output  ADDR_W  CPU load address.
REQ-012 load  output  1  one-cycle CPU write strobe.
REQ-013 is_instruction  output  1  load targets instruction memory (1) or data memory (0).
REQ-014 cpu_reset  output  1  active-high hold of the CPU; asserted except in RUN.
REQ-015 busy  output  1  high in LEN, DATA, CSUM.
REQ-016 error  output  1  high in ERROR.

Function
REQ-017 Frame: header byte, length byte, payload bytes, checksum byte.
REQ-018 Header: bit7 = is_instruction, bit6 = RUN command, bits[4:0] = start address, bit5 ignored.
REQ-019 Length byte: 1..31 = payload count; 0 means 32.
REQ-020 Checksum = XOR of header, length, and all payload bytes.
REQ-021 States: IDLE, LEN, DATA, CSUM, RUN, ERROR.
REQ-022 in_ready = 1 in IDLE, LEN, DATA, CSUM, ERROR; 0 in RUN.
REQ-023 IDLE: accepted header with bit6=0 latches flag/address, goes to LEN; with bit6=1 goes to RUN (no length, data, or checksum bytes follow).
REQ-024 LEN -> DATA on accept; remaining count loaded from the length byte.
REQ-025 DATA: each accepted byte produces, on the next cycle only, load=1, cpu_input=byte, load_address=current address, is_instruction=latched flag.
REQ-026 Address increments per payload byte modulo 32 (31 wraps to 0); back-to-back accepts produce back-to-back load pulses.
REQ-027 DATA -> CSUM after the final payload byte is accepted.
REQ-028 CSUM: match -> IDLE; mismatch -> ERROR. Loads already issued are not rolled back.
REQ-029 ERROR: accepted bytes are discarded without loads; clr_error -> IDLE.
REQ-030 RUN: cpu_reset=0. halt -> IDLE, with cpu_reset=1 from the next cycle.
REQ-031 halt in any other state has no effect; clr_error outside ERROR has no effect.
REQ-032 load is 0 on every cycle not following a DATA-state accept; cpu_input, load_address, and is_instruction hold their last values.
REQ-033 in_valid without in_ready changes no state.

Reset
REQ-034 While reset=1 and on the cycle after reset is released: state=IDLE, load=0, cpu_input=0, load_address=0, is_instruction=0, cpu_reset=1, busy=0, error=0.
REQ-035 Reset asserted mid-frame or in RUN overrides all inputs. The partial frame is abandoned with no further loads, and the CPU is held in reset.

Structure
REQ-036 Shared package cpu_pkg holds the state enumeration, header bit positions (HDR_INSTR=7, HDR_RUN=6), DATA_W, and ADDR_W.
REQ-037 One sub-module, loader_csum: a running XOR accumulator with clear and enable, cleared on header accept.
REQ-038 All outputs are registered.

Verification
REQ-039 Frame 0x83,0x02,0x11,0x22,csum=0x83^0x02^0x11^0x22=0xB2 -> load pulses at addr 3 data 0x11, then addr 4 data 0x22, is_instruction=1; returns to IDLE with error=0.
REQ-040 Frame 0x1E,0x03,0xAA,0xBB,0xCC,correct csum -> loads at addresses 30, 31, 0 (wrap); is_instruction=0.
REQ-041 Length byte 0x00 at address 0 -> exactly 32 load pulses at addresses 0..31.
REQ-042 Wrong checksum -> error=1, in_ready=1, no loads from later bytes; clr_error -> IDLE, error=0.
REQ-043 Header 0x40 -> cpu_reset=0, in_ready=0; halt -> cpu_reset=1 the next cycle and state IDLE.
REQ-044 reset asserted after the second payload byte -> no further load pulses, outputs at reset values, cpu_reset=1; a new frame then loads correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program loader: state encoding, header
// bit positions and default widths.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  // Header byte layout
  localparam int HDR_INSTR = 7;
  localparam int HDR_RUN   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/loader_csum.sv
// Running XOR accumulator over the bytes of one frame.
// When clr and en are both high, the accumulator restarts with din, so the
// header byte seeds the new checksum on the same cycle it is accepted.
module loader_csum #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] term;

  // Select the starting value and the byte folded in this cycle
  always_comb begin
    base = clr ? '0 : acc;
    term = en ? din : '0;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr || en) begin
      acc <= base ^ term;
    end
  end

endmodule

// File: rtl/cpu_loader.sv
// Host byte-stream loader for a small CPU.
// Parses framed writes (header, length, payload, checksum) into one-cycle
// load strobes, and starts/halts the CPU on command.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a header byte
//   ST_LEN   | header latched, waiting for the length byte
//   ST_DATA  | payload bytes; each accepted byte becomes one load strobe
//   ST_CSUM  | waiting for the checksum byte
//   ST_RUN   | CPU released from reset; stream is back-pressured
//   ST_ERROR | checksum mismatch; bytes swallowed until clr_error
module cpu_loader #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              halt,
  input  logic              clr_error,
  output logic [DATA_W-1:0] cpu_input,
  output logic [ADDR_W-1:0] load_address,
  output logic              load,
  output logic              is_instruction,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error
);

  import cpu_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W-1:0] addr;
  logic              instr_flag;
  logic              csum_clr;
  logic              csum_en;
  logic [DATA_W-1:0] csum_val;

  // Length byte to payload count: the low address bits give the count, and
  // zero stands for a full memory (2**ADDR_W bytes).
  function automatic logic [ADDR_W:0] len_to_count(input logic [DATA_W-1:0] len_byte);
    logic [ADDR_W-1:0] low;
    low = len_byte[ADDR_W-1:0];
    if (low == '0) begin
      len_to_count = {1'b1, {ADDR_W{1'b0}}};
    end else begin
      len_to_count = {1'b0, low};
    end
  endfunction

  assign accept = in_valid && in_ready;

  // Checksum covers header, length and payload; the header restarts it
  always_comb begin
    csum_clr = accept && (state == ST_IDLE);
    csum_en  = accept && ((state == ST_IDLE) || (state == ST_LEN) || (state == ST_DATA));
  end

  loader_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (csum_clr),
    .en    (csum_en),
    .din   (in_data),
    .acc   (csum_val)
  );

  // Next-state decode; status outputs are registered from this value
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = in_data[HDR_RUN] ? ST_RUN : ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && (remain == {{ADDR_W{1'b0}}, 1'b1})) begin
          state_nxt = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_nxt = (in_data == csum_val) ? ST_IDLE : ST_ERROR;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (clr_error) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, frame context and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b1;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      error          <= 1'b0;
      load           <= 1'b0;
      cpu_input      <= '0;
      load_address   <= '0;
      is_instruction <= 1'b0;
      addr           <= '0;
      instr_flag     <= 1'b0;
      remain         <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_RUN);
      cpu_reset <= (state_nxt != ST_RUN);
      busy      <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
      error     <= (state_nxt == ST_ERROR);
      load      <= 1'b0;

      if (accept) begin
        case (state)
          ST_IDLE: begin
            // A run command carries no frame, so the load context is kept
            if (!in_data[HDR_RUN]) begin
              instr_flag <= in_data[HDR_INSTR];
              addr       <= in_data[ADDR_W-1:0];
            end
          end
          ST_LEN: begin
            remain <= len_to_count(in_data);
          end
          ST_DATA: begin
            load           <= 1'b1;
            cpu_input      <= in_data;
            load_address   <= addr;
            is_instruction <= instr_flag;
            addr           <= addr + 1'b1;
            remain         <= remain - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
